// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         WIDTH_DEF   = 8;
    localparam int         DIGITS_DEF  = 3;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - per-digit double-dabble correction
//   i_digit  in  4  BCD digit before the shift
//   o_digit  out 4  digit + 3 when it is 5 or more, else unchanged
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Digits entering correction are at most 9, so the sum never exceeds 12.
    assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_conv_arb.sv
// rtl/bcd_conv_arb.sv - two-requester shared sequential binary-to-BCD converter
//   clk    in  1         system clock, rising edge
//   rst_n  in  1         asynchronous active-low reset
//   req    in  2         per-requester request level, held until ack
//   bin0   in  WIDTH     requester 0 operand
//   bin1   in  WIDTH     requester 1 operand
//   ack    out 2         one-hot one-cycle result-valid pulse
//   bcd    out 4*DIGITS  packed BCD result, digit 0 in bcd[3:0]
//   busy   out 1         conversion in progress
// Optional feature: BCD_ARB_RR_EN selects round-robin tie-breaking;
// otherwise requester 0 has fixed priority.
module bcd_conv_arb
    import bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [WIDTH-1:0]      bin0,
    input  logic [WIDTH-1:0]      bin1,
    output logic [1:0]            ack,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = 4 * DIGITS;

    state_t              r_state;
    logic [WIDTH-1:0]    r_shift;
    logic [DW-1:0]       r_digits;
    logic [CW-1:0]       r_cnt;
    // Current owner; with round-robin it doubles as the last-grant record
    // because it only changes on grant edges.
    logic                r_owner;
    logic [1:0]          r_ack;
    logic [DW-1:0]       r_bcd;
    logic                r_busy;

    logic [DW-1:0]       w_corr;
    logic [DW+WIDTH-1:0] w_shifted;
    logic [DW-1:0]       w_next_digits;
    logic [WIDTH-1:0]    w_next_shift;
    logic                w_sel;
    logic [WIDTH-1:0]    w_operand;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_digits[4*g +: 4]),
            .o_digit (w_corr[4*g +: 4])
        );
    end

    // Correct first, then shift: operand MSB lands in digit 0 bit 0.
    assign w_shifted     = {w_corr, r_shift} << 1;
    assign w_next_digits = w_shifted[DW+WIDTH-1:WIDTH];
    assign w_next_shift  = w_shifted[WIDTH-1:0];

    always_comb begin
        w_sel = r_owner;
        case (req)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
`ifdef BCD_ARB_RR_EN
            2'b11:   w_sel = ~r_owner;
`else
            2'b11:   w_sel = 1'b0;
`endif
            default: w_sel = r_owner;
        endcase
    end

    assign w_operand = w_sel ? bin1 : bin0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_digits <= '0;
            r_cnt    <= '0;
            r_owner  <= 1'b1;
            r_ack    <= 2'b00;
            r_bcd    <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 2'b00;
                    if (|req) begin
                        r_owner  <= w_sel;
                        r_shift  <= w_operand;
                        r_digits <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_digits <= w_next_digits;
                    r_shift  <= w_next_shift;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        // Publish the post-shift value on the same edge.
                        r_bcd   <= w_next_digits;
                        r_ack   <= r_owner ? 2'b10 : 2'b01;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ack   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack  = r_ack;
    assign bcd  = r_bcd;
    assign busy = r_busy;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// tb/tb_bcd_conv_arb.sv - directed self-checking bench for bcd_conv_arb
`timescale 1ns/1ps
module tb_bcd_conv_arb;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req   = 2'b00;
    logic [7:0]  bin0  = 8'd0;
    logic [7:0]  bin1  = 8'd0;
    logic [1:0]  ack;
    logic [11:0] bcd;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    bcd_conv_arb #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .bin0  (bin0),
        .bin1  (bin1),
        .ack   (ack),
        .bcd   (bcd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits on negedges for an ack pulse; n = negedges elapsed, bounded.
    task automatic wait_ack(output logic [1:0] a, output logic [11:0] b,
                            output int n, output logic busy1);
        a = 2'b00; b = 12'h000; n = 0; busy1 = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) busy1 = busy;
            if (ack != 2'b00) begin
                a = ack;
                b = bcd;
                break;
            end
        end
    endtask

    task automatic convert(input int who, input logic [7:0] val,
                           input logic [11:0] exp, input string tag);
        logic [1:0]  a;
        logic [11:0] b;
        int          n;
        logic        b1;
        if (who == 0) bin0 = val; else bin1 = val;
        req[who] = 1'b1;
        wait_ack(a, b, n, b1);
        req[who] = 1'b0;
        check({tag, "_ack"}, a, (who == 0) ? 2'b01 : 2'b10);
        check({tag, "_bcd"}, b, exp);
        check({tag, "_lat"}, n, 9);
        check({tag, "_busy_early"}, b1, 1'b1);
        @(negedge clk);
        check({tag, "_ack_clr"}, ack, 2'b00);
        check({tag, "_busy_clr"}, busy, 1'b0);
    endtask

    initial begin
        logic [1:0]  a;
        logic [11:0] b;
        int          n;
        logic        b1;
        int          pulses;

        repeat (3) @(negedge clk);
        check("rst_ack", ack, 2'b00);
        check("rst_bcd", bcd, 12'h000);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(0, 8'd255, 12'h255, "max255");

        convert(1, 8'd0,   12'h000, "b1_0");
        convert(1, 8'd9,   12'h009, "b1_9");
        convert(1, 8'd10,  12'h010, "b1_10");
        convert(1, 8'd99,  12'h099, "b1_99");
        convert(1, 8'd100, 12'h100, "b1_100");
        convert(1, 8'd128, 12'h128, "b1_128");

        // Tie with last grant = 1: requester 0 wins in both modes.
        bin0 = 8'd42; bin1 = 8'd137; req = 2'b11;
        wait_ack(a, b, n, b1);
        req[0] = 1'b0;
        check("tie1_ack", a, 2'b01);
        check("tie1_bcd", b, 12'h042);
        check("tie1_lat", n, 9);
        wait_ack(a, b, n, b1);
        req[1] = 1'b0;
        check("tie1b_ack", a, 2'b10);
        check("tie1b_bcd", b, 12'h137);
        check("tie1b_lat", n, 10);
        @(negedge clk);

        // Leave last grant = 0, then tie again.
        convert(0, 8'd42, 12'h042, "pre_tie2");
        req = 2'b11;
        wait_ack(a, b, n, b1);
`ifdef BCD_ARB_RR_EN
        req[1] = 1'b0;
        check("tie2_ack", a, 2'b10);
        check("tie2_bcd", b, 12'h137);
        wait_ack(a, b, n, b1);
        req[0] = 1'b0;
        check("tie2b_ack", a, 2'b01);
        check("tie2b_bcd", b, 12'h042);
`else
        req[0] = 1'b0;
        check("tie2_ack", a, 2'b01);
        check("tie2_bcd", b, 12'h042);
        wait_ack(a, b, n, b1);
        req[1] = 1'b0;
        check("tie2b_ack", a, 2'b10);
        check("tie2b_bcd", b, 12'h137);
`endif
        check("tie2b_lat", n, 10);
        @(negedge clk);

        // Operand change after the grant edge is ignored.
        bin0 = 8'd200; req[0] = 1'b1;
        @(negedge clk);
        bin0 = 8'd7;
        wait_ack(a, b, n, b1);
        req[0] = 1'b0;
        check("opchg_ack", a, 2'b01);
        check("opchg_bcd", b, 12'h200);
        check("opchg_lat", n, 8);
        @(negedge clk);

        // Reset during the 4th shift.
        bin1 = 8'd99; req[1] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; req = 2'b00;
        #1;
        check("midrst_ack", ack, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_bcd", bcd, 12'h000);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (ack != 2'b00) pulses++;
        end
        check("midrst_no_ack", pulses, 0);
        check("midrst_busy_after", busy, 1'b0);
        check("midrst_bcd_after", bcd, 12'h000);
        convert(1, 8'd99, 12'h099, "rereq");

        // Back-to-back with req[0] held through ack.
        bin0 = 8'd77; req[0] = 1'b1;
        wait_ack(a, b, n, b1);
        check("b2b1_ack", a, 2'b01);
        check("b2b1_bcd", b, 12'h077);
        check("b2b1_lat", n, 9);
        wait_ack(a, b, n, b1);
        req[0] = 1'b0;
        check("b2b2_ack", a, 2'b01);
        check("b2b2_bcd", b, 12'h077);
        check("b2b2_lat", n, 10);
        @(negedge clk);
        check("b2b_busy_clr", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
